parking_lot_counter: RTL and testbench

//  Downstream of the parking-lot entry/exit FSM. Consumes its car_enter/car_exit

---
 rtl/parking_lot_counter.sv | 121 ++++++++++++
 tb/tb_parking_lot_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/parking_lot_counter.sv
// Lot occupancy counter driven by entry/exit event strobes. It keeps a binary
// count and a BCD count in lockstep, registered flags, and sticky overflow/underflow errors.
module parking_lot_counter #(
    parameter int CAPACITY    = 50,
    parameter int NEAR_MARGIN = 5,
    parameter int CNT_W       = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             car_enter,
    input  logic             car_exit,
    input  logic             clear,
    input  logic             err_clr,
    output logic [CNT_W-1:0] occupancy,
    output logic [CNT_W-1:0] spaces_free,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             near_full,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] MARGIN   = CNT_W'(NEAR_MARGIN);
    localparam logic             NEAR_RST = (CAPACITY <= NEAR_MARGIN) ? 1'b1 : 1'b0;

    logic             enter_q, exit_q;
    logic [CNT_W-1:0] occ_q, occ_d, free_q, free_d;
    logic [3:0]       tens_q, tens_d, ones_q, ones_d;
    logic             full_q, full_d, empty_q, empty_d, near_q, near_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             enter_ev, exit_ev;

    always_comb begin
        enter_ev = car_enter & ~enter_q;
        exit_ev  = car_exit & ~exit_q;
        occ_d    = occ_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        // err_clr drops the flags, but an error raised this cycle re-sets them below
        ovf_d    = ovf_q & ~err_clr;
        unf_d    = unf_q & ~err_clr;
        if (clear) begin
            occ_d  = '0;
            tens_d = '0;
            ones_d = '0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end else if (enter_ev && !exit_ev) begin
            if (occ_q < CAP) begin
                occ_d = occ_q + 1'b1;
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end else if (exit_ev && !enter_ev) begin
            if (occ_q != '0) begin
                occ_d = occ_q - 1'b1;
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end else begin
                unf_d = 1'b1;
            end
        end
        // Flags come from the next count so they stay coherent with occupancy
        free_d  = CAP - occ_d;
        full_d  = (occ_d == CAP);
        empty_d = (occ_d == '0);
        near_d  = (free_d <= MARGIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            occ_q   <= '0;
            free_q  <= CAP;
            tens_q  <= '0;
            ones_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            near_q  <= NEAR_RST;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            enter_q <= car_enter;
            exit_q  <= car_exit;
            occ_q   <= occ_d;
            free_q  <= free_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            near_q  <= near_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign occupancy     = occ_q;
    assign spaces_free   = free_q;
    assign bcd_tens      = tens_q;
    assign bcd_ones      = ones_q;
    assign lot_full      = full_q;
    assign lot_empty     = empty_q;
    assign near_full     = near_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_parking_lot_counter.sv
// Randomized plus directed bench for parking_lot_counter: stimulus pushes expected
// outputs from an arithmetic lot model into a queue, and a monitor pops and checks each cycle.
module tb_parking_lot_counter;

    localparam int CAP = 50;
    localparam int MARGIN = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       car_enter = 1'b0, car_exit = 1'b0, clear = 1'b0, err_clr = 1'b0;
    logic [6:0] occupancy, spaces_free;
    logic [3:0] bcd_tens, bcd_ones;
    logic       lot_full, lot_empty, near_full, overflow_err, underflow_err;

    parking_lot_counter #(.CAPACITY(CAP), .NEAR_MARGIN(MARGIN), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .car_enter(car_enter), .car_exit(car_exit),
        .clear(clear), .err_clr(err_clr), .occupancy(occupancy), .spaces_free(spaces_free),
        .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .lot_full(lot_full), .lot_empty(lot_empty),
        .near_full(near_full), .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int occ;
        int ovf;
        int unf;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    // lot model: just a car count, previous input levels and two error bits
    int m_occ = 0, m_ovf = 0, m_unf = 0, m_pen = 0, m_pex = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("occupancy", int'(occupancy), e.occ);
        chk("spaces_free", int'(spaces_free), CAP - e.occ);
        chk("bcd_tens", int'(bcd_tens), e.occ / 10);
        chk("bcd_ones", int'(bcd_ones), e.occ % 10);
        chk("lot_full", int'(lot_full), (e.occ == CAP) ? 1 : 0);
        chk("lot_empty", int'(lot_empty), (e.occ == 0) ? 1 : 0);
        chk("near_full", int'(near_full), ((CAP - e.occ) <= MARGIN) ? 1 : 0);
        chk("overflow_err", int'(overflow_err), e.ovf);
        chk("underflow_err", int'(underflow_err), e.unf);
    endtask

    // monitor: every clock presents a new registered result
    always @(posedge clk) begin
        #1;
        cyc++;
        if (q.size() > 0) chk_all(q.pop_front());
    end

    task automatic step(input int en, input int ex, input int clr, input int eclr);
        int ev_en, ev_ex, set_o, set_u;
        exp_t e;
        @(negedge clk);
        car_enter = en[0]; car_exit = ex[0]; clear = clr[0]; err_clr = eclr[0];
        ev_en = en & ~m_pen;
        ev_ex = ex & ~m_pex;
        m_pen = en;
        m_pex = ex;
        set_o = 0;
        set_u = 0;
        if (clr != 0) begin
            m_occ = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (ev_en != 0 && ev_ex == 0) begin
                if (m_occ < CAP) m_occ++; else set_o = 1;
            end else if (ev_ex != 0 && ev_en == 0) begin
                if (m_occ > 0) m_occ--; else set_u = 1;
            end
            if (eclr != 0) begin m_ovf = 0; m_unf = 0; end
            if (set_o != 0) m_ovf = 1;
            if (set_u != 0) m_unf = 1;
        end
        e.occ = m_occ; e.ovf = m_ovf; e.unf = m_unf;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic pulses_in(input int n);
        for (int i = 0; i < n; i++) begin step(1, 0, 0, 0); step(0, 0, 0, 0); end
    endtask

    task automatic pulses_out(input int n);
        for (int i = 0; i < n; i++) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
    endtask

    // asynchronous reset asserted between edges; outputs must drop before the next edge
    task automatic mid_reset();
        exp_t z;
        z.occ = 0; z.ovf = 0; z.unf = 0;
        #3;
        rst_n = 1'b0;
        #1;
        chk_all(z);
        @(negedge clk);
        car_enter = 1'b0; car_exit = 1'b0; clear = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_occ = 0; m_ovf = 0; m_unf = 0; m_pen = 0; m_pex = 0;
    endtask

    initial begin
        exp_t z;
        int pe, px;
        z.occ = 0; z.ovf = 0; z.unf = 0;
        #7;
        chk_all(z);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        // wide pulse counts once, then 11 more
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
        pulses_in(11);
        // fill, overflow, err_clr
        pulses_in(38);
        pulses_in(1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        // down to 10, simultaneous events, then borrow to 9
        pulses_out(40);
        step(1, 1, 0, 0); step(0, 0, 0, 0);
        pulses_out(1);
        // underflow, then enter with err_clr
        pulses_out(9);
        step(0, 1, 0, 0);
        step(1, 0, 0, 1);
        step(0, 0, 0, 0);
        // clear beats enter
        pulses_in(29);
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        pulses_in(30);
        mid_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        // randomized phases biased toward filling, draining or balanced
        for (int i = 0; i < 3000; i++) begin
            case ((i / 250) % 3)
                0: begin pe = 60; px = 20; end
                1: begin pe = 20; px = 60; end
                default: begin pe = 40; px = 40; end
            endcase
            step(($urandom_range(0, 99) < pe) ? 1 : 0,
                 ($urandom_range(0, 99) < px) ? 1 : 0,
                 ($urandom_range(0, 127) == 0) ? 1 : 0,
                 ($urandom_range(0, 15) == 0) ? 1 : 0);
        end
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected results not consumed, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
